srrc_polyphase_interp_tx: RTL and testbench
===========================================

Name: srrc_polyphase_interp_tx

Overview:
- Time-shared polyphase SRRC pulse-shaping interpolator. Sits directly upstream of the halfband interpolator.
- Takes one 1s17 symbol per sym_clk_en and produces one 1s17 sample per sam_clk_en, with L samples per symbol.
- A single 18x18 multiplier is reused across TPP taps per output sample, clocked at clk.
- Coefficients are run-time loadable through a write port.

Parameters:
- L, 4, interpolation factor (samples per symbol); power of 2.
- TPP, 6, taps per polyphase branch; total taps = L*TPP.
- GUARD, 3, accumulator guard bits (>= ceil(log2(TPP))).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- sym_clk_en  in  1  symbol strobe; always coincident with a sam_clk_en.
- sam_clk_en  in  1  output-sample strobe; spacing >= TPP+2 clk.
- x_in  in  18  symbol, signed 1s17.
- coef_wr_en  in  1  coefficient write strobe.
- coef_addr  in  $clog2(L*TPP)  coefficient index n.
- coef_data  in  18  coefficient h[n], signed 1s17.
- y  out  18  output sample, signed 1s17.
- y_valid  out  1  one-clk pulse when y updates.
- busy  out  1  high while the MAC sequence runs.
- overrun  out  1  sticky error flag.

Behaviour:
Reset (async):
- Delay line x[0..TPP-1], coefficient RAM, accumulator, y: all 0.
- y_valid, busy, overrun: 0. State IDLE. Phase p = 0.

Delay line:
- On sym_clk_en: x[0] <= x_in, x[k] <= x[k-1]. Otherwise hold.

Phase:
- On sam_clk_en with sym_clk_en: p <= 0.
- On sam_clk_en alone: p <= (p+1) mod L.
- The MAC uses this updated p.

FSM states: IDLE, MAC, DONE.
- IDLE: on sam_clk_en, clear acc, k <= 0, busy <= 1, go to MAC.
- MAC: each clk, acc <= acc + x[k]*h[k*L+p], k <= k+1. After the TPP-th product, go to DONE.
- DONE: y <= out(acc), y_valid <= 1 for one clk, busy <= 0, return to IDLE.

Latency:
- y and y_valid change on clk edge TPP+2 after the edge that sampled sam_clk_en.
- y holds its value between updates.

Arithmetic:
- Product: 1s17 x 1s17 = 36-bit 2s34.
- Accumulator: 36+GUARD bits, sign-extended.
- out(acc): bits [34:17] of acc (truncate toward -inf), 1s17; see Optional Feature.

Coefficient writes:
- Accepted only when busy=0 and no sam_clk_en in the same cycle: h[coef_addr] <= coef_data.
- Otherwise dropped silently.
- An out-of-range coef_addr is dropped.

Boundary conditions:
- sam_clk_en while busy: ignored (no phase advance, no restart), overrun <= 1.
- sym_clk_en while busy: still shifts the delay line; overrun <= 1.
- overrun clears only on reset.
- Reset mid-MAC: aborts immediately; all state returns to reset values. The next sam_clk_en after release starts normally.

Optional Feature:
Macro SRRC_OUT_SAT_EN.
- Defined: if acc exceeds the 1s17 range (bits above 34 are not a sign extension of bit 34), y clamps to +131071 or -131072.
- Undefined: y = acc[34:17] with no check (wraps).

Test Plan:
1. Reset asserted, then released with no strobes -> y=0, y_valid=0, busy=0, overrun=0; every y_valid pulse stays 0 until the first sam_clk_en.
2. Impulse response: load h[n]=(n+1)*1024 for n=0..23; send symbol x=65536 (+0.5) followed by zeros; sym_clk_en every 4th sam_clk_en with spacing 10 clk -> 24 consecutive outputs y=(m+1)*512 for m=0..23, then 0. Each update is exactly 8 clk after its sam_clk_en.
3. Saturation (macro defined): all h=131071; six symbols of 131071 -> y=131071. Six symbols of -131072 -> y=-131072. Macro undefined: the same stimulus gives the wrapped acc[34:17] value.
4. Overrun: second sam_clk_en 3 clk after the first -> no extra y_valid, p advances once only, overrun=1 and stays 1 until reset.
5. Coefficient write while busy=1 -> h unchanged, verified by repeating scenario 2 outputs. The same write in IDLE takes effect.
6. Reset pulsed 2 clk into MAC -> busy=0, y=0 immediately. After release, scenario 2 reproduces identical results.

Source files
------------

// File: rtl/srrc_polyphase_interp_tx_if.sv
// Symbol/sample strobes, coefficient write port and sample output
// bundle for the SRRC polyphase interpolator.
interface srrc_polyphase_interp_tx_if #(
  parameter int L   = 4,
  parameter int TPP = 6
);
  localparam int AW = $clog2(L * TPP);

  logic               sym_clk_en;
  logic               sam_clk_en;
  logic signed [17:0] x_in;
  logic               coef_wr_en;
  logic [AW-1:0]      coef_addr;
  logic signed [17:0] coef_data;
  logic signed [17:0] y;
  logic               y_valid;
  logic               busy;
  logic               overrun;

  modport master (
    output sym_clk_en, sam_clk_en, x_in,
    output coef_wr_en, coef_addr, coef_data,
    input  y, y_valid, busy, overrun
  );

  modport slave (
    input  sym_clk_en, sam_clk_en, x_in,
    input  coef_wr_en, coef_addr, coef_data,
    output y, y_valid, busy, overrun
  );
endinterface

// File: rtl/srrc_polyphase_interp_tx.sv
// Time-shared polyphase SRRC interpolator, one registered 18x18 MAC.
// Define SRRC_OUT_SAT_EN to clamp the output instead of wrapping.
module srrc_polyphase_interp_tx #(
  parameter int L     = 4,
  parameter int TPP   = 6,
  parameter int GUARD = 3
) (
  input logic clk,
  input logic reset,
  srrc_polyphase_interp_tx_if.slave bus
);
  localparam int N   = L * TPP;
  localparam int AW  = $clog2(N);
  localparam int KW  = $clog2(TPP + 1);
  localparam int XW  = (TPP > 1) ? $clog2(TPP) : 1;
  localparam int PW  = (L > 1) ? $clog2(L) : 1;
  localparam int PRW = 36;
  localparam int ACW = PRW + GUARD;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                state_q, state_d;
  logic signed [17:0]    x_q [TPP];
  logic signed [17:0]    x_d [TPP];
  logic signed [17:0]    h_q [N];
  logic signed [17:0]    h_d [N];
  logic signed [PRW-1:0] prod_q, prod_d;
  logic signed [ACW-1:0] acc_q, acc_d;
  logic [KW-1:0]         k_q, k_d;
  logic [PW-1:0]         p_q, p_d;
  logic signed [17:0]    y_q, y_d;
  logic                  y_valid_q, y_valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic [KW-1:0]         kk;
  logic [AW-1:0]         hidx;
  logic                  wr_ok;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    h_d       = h_q;
    prod_d    = prod_q;
    acc_d     = acc_q;
    k_d       = k_q;
    p_d       = p_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    kk   = (k_q < KW'(TPP)) ? k_q : '0;
    hidx = AW'(int'(kk) * L + int'(p_q));

    // The delay line keeps shifting even mid-MAC.
    if (bus.sym_clk_en) begin
      x_d[0] = bus.x_in;
      for (int i = 1; i < TPP; i++) x_d[i] = x_q[i-1];
    end

    if (busy_q && (bus.sam_clk_en || bus.sym_clk_en))
      overrun_d = 1'b1;

    wr_ok = bus.coef_wr_en && !busy_q && !bus.sam_clk_en &&
            ({1'b0, bus.coef_addr} < (AW+1)'(N));
    if (wr_ok) h_d[bus.coef_addr] = bus.coef_data;

    unique case (state_q)
      IDLE: begin
        y_valid_d = 1'b0;
        if (bus.sam_clk_en) begin
          p_d     = bus.sym_clk_en ? '0 : p_q + PW'(1);
          acc_d   = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        // Product is registered, so the accumulate trails by one clk.
        if (k_q < KW'(TPP))
          prod_d = PRW'(x_q[XW'(kk)]) * PRW'(h_q[hidx]);
        if (k_q != '0)
          acc_d = acc_q + ACW'(prod_q);
        k_d = k_q + KW'(1);
        if (k_q == KW'(TPP)) state_d = DONE;
      end
      DONE: begin
`ifdef SRRC_OUT_SAT_EN
        if (!(&acc_q[ACW-1:34]) && (|acc_q[ACW-1:34]))
          y_d = acc_q[ACW-1] ? 18'sh20000 : 18'sh1FFFF;
        else
          y_d = acc_q[34:17];
`else
        y_d = acc_q[34:17];
`endif
        y_valid_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      for (int i = 0; i < TPP; i++) x_q[i] <= '0;
      for (int i = 0; i < N; i++) h_q[i] <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      p_q       <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      h_q       <= h_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      p_q       <= p_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_srrc_polyphase_interp_tx.sv
// Directed + randomized bench for the SRRC polyphase interpolator,
// checked against a sum-of-products reference model.
module tb_srrc_polyphase_interp_tx;
  localparam int L   = 4;
  localparam int TPP = 6;
  localparam int N   = L * TPP;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  srrc_polyphase_interp_tx_if #(.L(L), .TPP(TPP)) b();

  srrc_polyphase_interp_tx #(.L(L), .TPP(TPP), .GUARD(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  int checks = 0;
  int errors = 0;
  int h_m [N];
  int hist [TPP];
  int p_m = 0;
  int exp_y = 0;
  int e0 = 0;
  int yobs = 0;
  int cnt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // y for the current phase: dot product of history and branch taps.
  function automatic int model_y();
    longint acc = 0;
    longint s;
    int v;
    for (int k = 0; k < TPP; k++)
      acc += longint'(hist[k]) * longint'(h_m[k*L + p_m]);
`ifdef SRRC_OUT_SAT_EN
    if (acc > 64'sd17179869183) return 131071;
    if (acc < -64'sd17179869184) return -131072;
`endif
    s = acc >>> 17;
    v = int'(s & 64'h3FFFF);
    if (v >= 131072) v -= 262144;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) h_m[i] = 0;
    for (int i = 0; i < TPP; i++) hist[i] = 0;
    p_m = 0;
  endfunction

  task automatic start(input bit sym, input int xv);
    @(negedge clk);
    b.sym_clk_en = sym;
    b.sam_clk_en = 1'b1;
    b.x_in       = 18'(xv);
    @(posedge clk);
    #1;
    e0 = cyc;
    b.sym_clk_en = 1'b0;
    b.sam_clk_en = 1'b0;
    if (sym) begin
      for (int i = TPP - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = xv;
      p_m = 0;
    end else begin
      p_m = (p_m + 1) % L;
    end
    exp_y = model_y();
  endtask

  task automatic finish(output int yo);
    bit got = 1'b0;
    while (!got && (cyc - e0) < 20) begin
      @(posedge clk);
      #1;
      got = b.y_valid;
    end
    chk("latency", got ? cyc - e0 : -1, 8);
    yo = int'($signed(b.y));
    chk("y", yo, exp_y);
    @(posedge clk);
    #1;
    chk("pulse", int'(b.y_valid), 0);
  endtask

  task automatic sample(input bit sym, input int xv);
    start(sym, xv);
    finish(yobs);
  endtask

  task automatic wr(input int a, input int d, input bit upd);
    @(negedge clk);
    b.coef_wr_en = 1'b1;
    b.coef_addr  = 5'(a);
    b.coef_data  = 18'(d);
    @(negedge clk);
    b.coef_wr_en = 1'b0;
    if (upd && a < N) h_m[a] = d;
  endtask

  task automatic load_ramp();
    for (int n = 0; n < N; n++) wr(n, (n + 1) * 1024, 1'b1);
  endtask

  task automatic impulse();
    for (int i = 0; i < TPP; i++) sample(1'b1, 0);
    for (int m = 0; m < 28; m++) begin
      sample(m % 4 == 0, (m == 0) ? 65536 : 0);
      chk("impulse", yobs, (m < 24) ? (m + 1) * 512 : 0);
    end
  endtask

  initial begin
    b.sym_clk_en = 1'b0;
    b.sam_clk_en = 1'b0;
    b.x_in       = '0;
    b.coef_wr_en = 1'b0;
    b.coef_addr  = '0;
    b.coef_data  = '0;
    model_reset();

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_y", int'($signed(b.y)), 0);
    chk("rst_valid", int'(b.y_valid), 0);
    chk("rst_busy", int'(b.busy), 0);
    chk("rst_overrun", int'(b.overrun), 0);
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      cnt += int'(b.y_valid);
    end
    chk("idle_valid", cnt, 0);

    load_ramp();
    wr(25, 777, 1'b1);
    impulse();

    for (int n = 0; n < N; n++) wr(n, 131071, 1'b1);
    for (int i = 0; i < TPP; i++) sample(1'b1, 131071);
`ifdef SRRC_OUT_SAT_EN
    chk("sat_pos", yobs, 131071);
`else
    chk("wrap_pos", yobs, -12);
`endif
    for (int i = 0; i < TPP; i++) sample(1'b1, -131072);
`ifdef SRRC_OUT_SAT_EN
    chk("sat_neg", yobs, -131072);
`else
    chk("wrap_neg", yobs, 6);
`endif

    for (int n = 0; n < N; n++)
      wr(n, int'($urandom_range(0, 262143)) - 131072, 1'b1);
    for (int i = 0; i < 40; i++)
      sample($urandom_range(0, 3) == 0,
             int'($urandom_range(0, 262143)) - 131072);

    chk("no_overrun", int'(b.overrun), 0);
    start(1'b0, 0);
    repeat (3) @(negedge clk);
    b.sam_clk_en = 1'b1;
    @(negedge clk);
    b.sam_clk_en = 1'b0;
    finish(yobs);
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      cnt += int'(b.y_valid);
    end
    chk("ovr_extra", cnt, 0);
    chk("ovr_flag", int'(b.overrun), 1);
    sample(1'b0, 0);
    sample(1'b1, 5000);
    chk("ovr_sticky", int'(b.overrun), 1);

    load_ramp();
    start(1'b1, 0);
    @(negedge clk);
    b.coef_wr_en = 1'b1;
    b.coef_addr  = 5'd0;
    b.coef_data  = 18'd7;
    @(negedge clk);
    b.coef_wr_en = 1'b0;
    finish(yobs);
    impulse();
    wr(0, -40000, 1'b1);
    sample(1'b1, 70000);
    sample(1'b1, -12345);

    start(1'b1, 65536);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_busy", int'(b.busy), 0);
    chk("mid_y", int'($signed(b.y)), 0);
    chk("mid_overrun", int'(b.overrun), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    load_ramp();
    impulse();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $fatal(1, "FAIL timeout observed=%0d expected=finished", cyc);
  end
endmodule
